// File: rtl/fantasy_pkg.sv
// Shared types and elaboration helpers for the block-invert datapath:
// output mode encoding, BT.601-style luma weights and sizing functions.
package fantasy_pkg;

  typedef enum logic [1:0] {
    MODE_BLK     = 2'b00,
    MODE_NEVER   = 2'b01,
    MODE_ALWAYS  = 2'b10,
    MODE_INV_BLK = 2'b11
  } mode_e;

  // Weights sum to 256, so (weighted sum >> 8) stays within DW bits.
  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  function automatic int unsigned acc_width(int unsigned kh, int unsigned kv, int unsigned dw);
    return $clog2(kh * kv * ((1 << dw) - 1) + 1);
  endfunction

  function automatic int unsigned ceil_div(int unsigned a, int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/blk_cursor.sv
// Raster cursor: vs/de edge detection, column/line and block counters. All
// outputs are registered so they line up with the pixel held in stage S1.
module blk_cursor
  import fantasy_pkg::*;
#(
  parameter int unsigned H_WIDTH  = 1920,
  parameter int unsigned V_HEIGHT = 1080,
  parameter int unsigned KH       = 30,
  parameter int unsigned KV       = 30,
  parameter int unsigned HT_W     = 1,
  parameter int unsigned VT_W     = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            vs_i,
  input  logic            de_i,
  output logic            frame_start_o,
  output logic            pix_vld_o,
  output logic            last_o,
  output logic [HT_W-1:0] ht_o,
  output logic [VT_W-1:0] vt_o
);
  localparam int unsigned COL_W = $clog2(H_WIDTH + 1);
  localparam int unsigned LIN_W = $clog2(V_HEIGHT + 1);
  localparam int unsigned BX_W  = (KH > 1) ? $clog2(KH) : 1;
  localparam int unsigned BY_W  = (KV > 1) ? $clog2(KV) : 1;
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_WIDTH - 1);
  localparam logic [LIN_W-1:0] LIN_MAX  = LIN_W'(V_HEIGHT);
  localparam logic [LIN_W-1:0] LIN_LAST = LIN_W'(V_HEIGHT - 1);
  localparam logic [BX_W-1:0]  BX_LAST  = BX_W'(KH - 1);
  localparam logic [BY_W-1:0]  BY_LAST  = BY_W'(KV - 1);

  logic             vs_q, de_q, vs_rise, de_fall, col_in, line_in, blk_end;
  logic [COL_W-1:0] col_q, col_c, col_d;
  logic [LIN_W-1:0] line_q, line_c, line_d;
  logic [BX_W-1:0]  bx_q, bx_c, bx_d;
  logic [BY_W-1:0]  by_q, by_c, by_d;
  logic [HT_W-1:0]  ht_q, ht_c, ht_d;
  logic [VT_W-1:0]  vt_q, vt_c, vt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vs_rise = vs_i & ~vs_q;
    de_fall = de_q & ~de_i;
    // A vs rise restarts the raster for the pixel arriving in the same cycle.
    col_c   = vs_rise ? '0 : col_q;
    line_c  = vs_rise ? '0 : line_q;
    bx_c    = vs_rise ? '0 : bx_q;
    by_c    = vs_rise ? '0 : by_q;
    ht_c    = vs_rise ? '0 : ht_q;
    vt_c    = vs_rise ? '0 : vt_q;
    col_in  = col_c < COL_MAX;
    line_in = line_c < LIN_MAX;
    blk_end = (bx_c == BX_LAST || col_c == COL_LAST) && (by_c == BY_LAST || line_c == LIN_LAST);
    col_d   = col_c;
    line_d  = line_c;
    bx_d    = bx_c;
    by_d    = by_c;
    ht_d    = ht_c;
    vt_d    = vt_c;
    if (de_i) begin
      if (col_in) begin
        col_d = col_c + 1'b1;
        if (bx_c == BX_LAST) begin
          bx_d = '0;
          ht_d = ht_c + 1'b1;
        end else begin
          bx_d = bx_c + 1'b1;
        end
      end
    end else if (de_fall && !vs_rise) begin
      col_d = '0;
      bx_d  = '0;
      ht_d  = '0;
      if (line_in) begin
        line_d = line_c + 1'b1;
        if (by_c == BY_LAST) begin
          by_d = '0;
          vt_d = vt_c + 1'b1;
        end else begin
          by_d = by_c + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q <= 1'b0; de_q <= 1'b0;
      col_q <= '0; line_q <= '0; bx_q <= '0; by_q <= '0; ht_q <= '0; vt_q <= '0;
      frame_start_o <= 1'b0; pix_vld_o <= 1'b0; last_o <= 1'b0;
      ht_o <= '0; vt_o <= '0;
    end else begin
      vs_q <= vs_i; de_q <= de_i;
      col_q <= col_d; line_q <= line_d; bx_q <= bx_d; by_q <= by_d; ht_q <= ht_d; vt_q <= vt_d;
      frame_start_o <= vs_rise;
      pix_vld_o     <= de_i & col_in & line_in;
      last_o        <= de_i & col_in & line_in & blk_end;
      ht_o          <= ht_c;
      vt_o          <= vt_c;
    end
  end

endmodule

// File: rtl/blk_invert_engine.sv
// Per-block luma mean thresholding with a double-buffered invert bitmap; frame N-1
// decisions invert frame N pixels. Define HYST_EN to enable decision hysteresis.
module blk_invert_engine
  import fantasy_pkg::*;
#(
  parameter int unsigned H_WIDTH  = 1920,
  parameter int unsigned V_HEIGHT = 1080,
  parameter int unsigned KH       = 30,
  parameter int unsigned KV       = 30,
  parameter int unsigned DW       = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            hs_i,
  input  logic            vs_i,
  input  logic            de_i,
  input  logic [3*DW-1:0] data_i,
  input  logic [1:0]      mode_i,
  input  logic            bypass_i,
  input  logic [DW-1:0]   thr_i,
  input  logic [DW-1:0]   hyst_i,
  output logic            hs_o,
  output logic            vs_o,
  output logic            de_o,
  output logic [3*DW-1:0] data_o,
  output logic            px_inv_o
);
  localparam int unsigned HBLKS  = ceil_div(H_WIDTH, KH);
  localparam int unsigned VBLKS  = ceil_div(V_HEIGHT, KV);
  localparam int unsigned NBLK   = HBLKS * VBLKS;
  localparam int unsigned HT_W   = (HBLKS > 1) ? $clog2(HBLKS) : 1;
  localparam int unsigned VT_W   = (VBLKS > 1) ? $clog2(VBLKS) : 1;
  localparam int unsigned IDX_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned ACC_W  = acc_width(KH, KV, DW);
  localparam int unsigned NPIX_W = $clog2(KH * KV + 1);
  localparam int unsigned CMP_W  = DW + NPIX_W;
  localparam int unsigned EDGE_W = H_WIDTH - (HBLKS - 1) * KH;
  localparam int unsigned EDGE_H = V_HEIGHT - (VBLKS - 1) * KV;
  localparam logic [NPIX_W-1:0] NPIX_FULL   = NPIX_W'(KH * KV);
  localparam logic [NPIX_W-1:0] NPIX_RIGHT  = NPIX_W'(EDGE_W * KV);
  localparam logic [NPIX_W-1:0] NPIX_BOTTOM = NPIX_W'(KH * EDGE_H);
  localparam logic [NPIX_W-1:0] NPIX_CORNER = NPIX_W'(EDGE_W * EDGE_H);
  localparam logic [HT_W-1:0]   HT_LAST     = HT_W'(HBLKS - 1);
  localparam logic [VT_W-1:0]   VT_LAST     = VT_W'(VBLKS - 1);

  logic              hs1_q, vs1_q, de1_q;
  logic [3*DW-1:0]   data1_q;
  logic [DW-1:0]     gray1_q;
  logic [DW+7:0]     luma_c;
  logic              frame_start, pix_vld, blk_last;
  logic [HT_W-1:0]   ht;
  logic [VT_W-1:0]   vt;
  logic [ACC_W-1:0]  row_acc_q [HBLKS];
  logic [ACC_W-1:0]  acc_base, sum_c;
  logic [NBLK-1:0]   bank_q [2];
  logic              bank_sel_q, rd_sel, prev_bit, blk_x, invert_c, px_inv_c, strict;
  logic [IDX_W-1:0]  blk_idx;
  logic [NPIX_W-1:0] npix_c;
  logic [DW-1:0]     thr_eff;
  logic [CMP_W-1:0]  limit_c;

  assign luma_c = (DW+8)'(data_i[3*DW-1:2*DW]) * (DW+8)'(LUMA_R)
                + (DW+8)'(data_i[2*DW-1:DW])   * (DW+8)'(LUMA_G)
                + (DW+8)'(data_i[DW-1:0])      * (DW+8)'(LUMA_B);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0; data1_q <= '0; gray1_q <= '0;
    end else begin
      hs1_q <= hs_i; vs1_q <= vs_i; de1_q <= de_i; data1_q <= data_i;
      gray1_q <= luma_c[DW+7:8];
    end
  end

  blk_cursor #(
    .H_WIDTH(H_WIDTH), .V_HEIGHT(V_HEIGHT), .KH(KH), .KV(KV), .HT_W(HT_W), .VT_W(VT_W)
  ) u_cursor (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .vs_i         (vs_i),
    .de_i         (de_i),
    .frame_start_o(frame_start),
    .pix_vld_o    (pix_vld),
    .last_o       (blk_last),
    .ht_o         (ht),
    .vt_o         (vt)
  );

  // The first pixel of a frame already reads the freshly swapped bank.
  assign rd_sel   = bank_sel_q ^ frame_start;
  assign blk_idx  = IDX_W'(vt) * IDX_W'(HBLKS) + IDX_W'(ht);
  assign prev_bit = bank_q[rd_sel][blk_idx];
  assign blk_x    = pix_vld & prev_bit;
  assign acc_base = frame_start ? '0 : row_acc_q[ht];
  assign sum_c    = acc_base + ACC_W'(gray1_q);

  always_comb begin
    unique case ({ht == HT_LAST, vt == VT_LAST})
      2'b10:   npix_c = NPIX_RIGHT;
      2'b01:   npix_c = NPIX_BOTTOM;
      2'b11:   npix_c = NPIX_CORNER;
      default: npix_c = NPIX_FULL;
    endcase
  end

`ifdef HYST_EN
  logic [DW:0] thr_hi_c;
  always_comb begin
    thr_hi_c = {1'b0, thr_i} + {1'b0, hyst_i};
    if (prev_bit) begin
      thr_eff = (thr_i > hyst_i) ? thr_i - hyst_i : '0;
      strict  = 1'b0;
    end else begin
      thr_eff = thr_hi_c[DW] ? '1 : thr_hi_c[DW-1:0];
      strict  = 1'b1;
    end
  end
`else
  logic unused_hyst;
  assign unused_hyst = ^hyst_i;
  always_comb begin
    thr_eff = thr_i;
    strict  = 1'b1;
  end
`endif

  // Mean comparison without division: sum against threshold times pixel count.
  assign limit_c  = CMP_W'(thr_eff) * CMP_W'(npix_c);
  assign invert_c = strict ? (CMP_W'(sum_c) > limit_c) : (CMP_W'(sum_c) >= limit_c);

  // NOTE: accumulators and bitmap banks are reset because stale bits would be displayed next frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(HBLKS); i++) row_acc_q[i] <= '0;
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      bank_sel_q <= 1'b0;
    end else begin
      if (frame_start) begin
        bank_sel_q <= ~bank_sel_q;
        for (int i = 0; i < int'(HBLKS); i++) row_acc_q[i] <= '0;
      end
      if (pix_vld) row_acc_q[ht] <= blk_last ? '0 : sum_c;
      if (pix_vld && blk_last) bank_q[~rd_sel][blk_idx] <= invert_c;
    end
  end

  always_comb begin
    px_inv_c = 1'b0;
    if (!bypass_i) begin
      unique case (mode_e'(mode_i))
        MODE_BLK:     px_inv_c = blk_x;
        MODE_NEVER:   px_inv_c = 1'b0;
        MODE_ALWAYS:  px_inv_c = 1'b1;
        MODE_INV_BLK: px_inv_c = ~blk_x;
        default:      px_inv_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_o <= 1'b0; vs_o <= 1'b0; de_o <= 1'b0; data_o <= '0; px_inv_o <= 1'b0;
    end else begin
      hs_o     <= hs1_q;
      vs_o     <= vs1_q;
      de_o     <= de1_q;
      data_o   <= data1_q ^ {3*DW{px_inv_c}};
      px_inv_o <= px_inv_c;
    end
  end

endmodule
